// File: rtl/binbcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter:
// state encodings, add-3 correction constants and the digit-count helper.
package binbcd_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ADJUST = 2'd1;
    localparam logic [1:0] SHIFT  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_VAL    = 4'd3;

    // Smallest number of decimal digits able to hold 2^bits - 1.
    function automatic int unsigned min_digits(input int unsigned bits);
        longint unsigned one;
        longint unsigned maxval;
        longint unsigned pw;
        int unsigned     d;
        one    = 64'd1;
        maxval = (one << bits) - one;
        pw     = 64'd10;
        d      = 1;
        for (int unsigned i = 0; i < 20; i++) begin
            if (pw <= maxval) begin
                pw = pw * 64'd10;
                d  = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/binbcd_seq_ctrl_add3.sv
// One BCD digit of the shift-and-add-3 correction: digits of 5 or more
// get 3 added so the following left shift carries into the next digit.
module add3_digit
    import binbcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Conditional +3 correction of a single digit.
    always_comb begin
        dout = din;
        if (din >= ADD3_THRESH) begin
            dout = din + ADD3_VAL;
        end
    end

endmodule

// File: rtl/binbcd_seq_ctrl.sv
// Multi-cycle binary-to-BCD converter: captures an operand on start, runs
// one ADJUST/SHIFT pair per operand bit, then strobes done with a
// registered packed BCD result that holds until the next completion.
module binbcd_seq_ctrl
    import binbcd_pkg::*;
#(
    parameter int unsigned BITS   = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BITS-1:0]       bindata,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = (BITS > 1) ? $clog2(BITS) : 1;

    if (DIGITS < min_digits(BITS)) begin : g_digits_too_few
        $error("binbcd_seq_ctrl: DIGITS too small for BITS");
    end

    logic [1:0]      state;
    logic [BITS-1:0] bin_sr;
    logic [W-1:0]    work;
    logic [W-1:0]    work_adj;
    logic [W-1:0]    work_shl;
    logic [CW-1:0]   cnt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        add3_digit u_add3 (
            .din  (work[4*g +: 4]),
            .dout (work_adj[4*g +: 4])
        );
    end

    // Work register after shifting in the next operand bit.
    always_comb begin
        work_shl = {work[W-2:0], bin_sr[BITS-1]};
    end

    // Controller FSM, bit counter and {work, bin_sr} shift register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            bin_sr <= '0;
            work   <= '0;
            cnt    <= '0;
            bcd    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr <= bindata;
                        work   <= '0;
                        cnt    <= '0;
                        state  <= ADJUST;
                    end
                end
                ADJUST: begin
                    work  <= work_adj;
                    state <= SHIFT;
                end
                SHIFT: begin
                    work   <= work_shl;
                    bin_sr <= bin_sr << 1;
                    if (cnt == CW'(BITS - 1)) begin
                        bcd   <= work_shl;
                        state <= DONE;
                    end else begin
                        cnt   <= cnt + CW'(1);
                        state <= ADJUST;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        busy = (state == ADJUST) || (state == SHIFT);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_binbcd_seq_ctrl.sv
// Directed bench for binbcd_seq_ctrl (8-bit/3-digit and 10-bit/4-digit).
module tb_binbcd_seq_ctrl;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  bindata;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    logic        start10;
    logic [9:0]  bindata10;
    logic        busy10;
    logic        done10;
    logic [15:0] bcd10;

    int n_cmp;
    int n_bad;

    binbcd_seq_ctrl #(.BITS(8), .DIGITS(3)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .bindata (bindata),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd)
    );

    binbcd_seq_ctrl #(.BITS(10), .DIGITS(4)) dut10 (
        .clock   (clock),
        .reset   (reset),
        .start   (start10),
        .bindata (bindata10),
        .busy    (busy10),
        .done    (done10),
        .bcd     (bcd10)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One rising edge, then settle before sampling or driving.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Pulse start for one edge and check done/bcd at E16 and E17.
    task automatic convert8(input logic [7:0] v, input logic [11:0] exp, input string name);
        bindata = v;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 15; i++) tick();
        tick();
        n_cmp++;
        if (done !== 1'b1 || bcd !== exp) begin
            n_bad++;
            $display("FAIL %s_e16: done=%b bcd=%h, required done=1 bcd=%h", name, done, bcd, exp);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_e17: done=%b, required 0", name, done);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b bcd=%h, required 0 0 000", busy, done, bcd);
        end
        n_cmp++;
        if (busy10 !== 1'b0 || done10 !== 1'b0 || bcd10 !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_state10: busy=%b done=%b bcd=%h, required 0 0 0000", busy10, done10, bcd10);
        end
    endtask

    task automatic test_latency_255;
        bindata = 8'd255;
        start   = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL lat_e0: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        for (int i = 1; i <= 15; i++) begin
            tick();
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0 || bcd !== 12'h000) begin
                n_bad++;
                $display("FAIL lat_e%0d: busy=%b done=%b bcd=%h, required 1 0 000", i, busy, done, bcd);
            end
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b1 || bcd !== 12'h255) begin
            n_bad++;
            $display("FAIL lat_e16: busy=%b done=%b bcd=%h, required 0 1 255", busy, done, bcd);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || bcd !== 12'h255) begin
            n_bad++;
            $display("FAIL lat_e17: busy=%b done=%b bcd=%h, required 0 0 255", busy, done, bcd);
        end
    endtask

    task automatic test_vectors;
        convert8(8'd0,   12'h000, "vec0");
        convert8(8'd128, 12'h128, "vec128");
        convert8(8'd9,   12'h009, "vec9");
    endtask

    task automatic test_ignore_start;
        int          ndone;
        logic [11:0] seen;
        ndone   = 0;
        seen    = '0;
        bindata = 8'd99;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        bindata = 8'd200;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 6; i <= 30; i++) begin
            tick();
            if (done === 1'b1) begin
                ndone++;
                seen = bcd;
            end
        end
        n_cmp++;
        if (ndone != 1) begin
            n_bad++;
            $display("FAIL ign_done_count: got %0d strobes, required 1", ndone);
        end
        n_cmp++;
        if (seen !== 12'h099) begin
            n_bad++;
            $display("FAIL ign_bcd: bcd=%h, required 099", seen);
        end
    endtask

    task automatic test_back_to_back;
        int          d1;
        int          d2;
        logic [11:0] b1;
        logic [11:0] b2;
        d1 = -1;
        d2 = -1;
        b1 = '0;
        b2 = '0;
        bindata = 8'd99;
        start   = 1'b1;
        tick();
        bindata = 8'd200;
        for (int e = 1; e <= 40 && d2 < 0; e++) begin
            tick();
            if (done === 1'b1) begin
                if (d1 < 0) begin
                    d1 = e;
                    b1 = bcd;
                end else begin
                    d2 = e;
                    b2 = bcd;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (d1 != 16 || b1 !== 12'h099) begin
            n_bad++;
            $display("FAIL b2b_first: edge=%0d bcd=%h, required edge=16 bcd=099", d1, b1);
        end
        n_cmp++;
        if (d2 != 34 || b2 !== 12'h200) begin
            n_bad++;
            $display("FAIL b2b_second: edge=%0d bcd=%h, required edge=34 bcd=200", d2, b2);
        end
        n_cmp++;
        if (d2 - d1 != 18) begin
            n_bad++;
            $display("FAIL b2b_spacing: %0d edges, required 18", d2 - d1);
        end
    endtask

    task automatic test_reset_mid;
        int ndone;
        ndone = 0;
        convert8(8'd42, 12'h042, "pre42");
        bindata = 8'd255;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 6; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
            n_bad++;
            $display("FAIL midrst_state: busy=%b done=%b bcd=%h, required 0 0 000", busy, done, bcd);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        n_cmp++;
        if (ndone != 0) begin
            n_bad++;
            $display("FAIL midrst_nodone: got %0d strobes, required 0", ndone);
        end
        convert8(8'd17, 12'h017, "post17");
    endtask

    task automatic test_sweep8;
        int bad_digits;
        bad_digits = 0;
        bindata = 8'd0;
        start   = 1'b1;
        for (int v = 0; v < 256; v++) begin
            int w;
            w = 0;
            while (done !== 1'b1 && w < 40) begin
                tick();
                w++;
            end
            n_cmp++;
            if (done !== 1'b1) begin
                n_bad++;
                $display("FAIL sweep8_timeout: operand %0d, no done within 40 edges", v);
                break;
            end
            if (bcd !== ref_bcd(v)) begin
                n_bad++;
                $display("FAIL sweep8_%0d: bcd=%h, required %h", v, bcd, ref_bcd(v) & 16'h0fff);
            end
            for (int d = 0; d < 3; d++) begin
                if (bcd[4*d +: 4] > 4'd9) bad_digits++;
            end
            bindata = 8'(v + 1);
            tick();
        end
        start = 1'b0;
        tick();
        tick();
        tick();
        n_cmp++;
        if (bad_digits != 0) begin
            n_bad++;
            $display("FAIL sweep8_digit_range: %0d digits above 9, required 0", bad_digits);
        end
    endtask

    task automatic test_sweep10;
        int bad_digits;
        bad_digits = 0;
        bindata10 = 10'd0;
        start10   = 1'b1;
        for (int v = 0; v < 1024; v++) begin
            int w;
            w = 0;
            while (done10 !== 1'b1 && w < 40) begin
                tick();
                w++;
            end
            n_cmp++;
            if (done10 !== 1'b1) begin
                n_bad++;
                $display("FAIL sweep10_timeout: operand %0d, no done within 40 edges", v);
                break;
            end
            if (bcd10 !== ref_bcd(v)) begin
                n_bad++;
                $display("FAIL sweep10_%0d: bcd=%h, required %h", v, bcd10, ref_bcd(v));
            end
            for (int d = 0; d < 4; d++) begin
                if (bcd10[4*d +: 4] > 4'd9) bad_digits++;
            end
            bindata10 = 10'(v + 1);
            tick();
        end
        start10 = 1'b0;
        tick();
        tick();
        tick();
        n_cmp++;
        if (bad_digits != 0) begin
            n_bad++;
            $display("FAIL sweep10_digit_range: %0d digits above 9, required 0", bad_digits);
        end
        n_cmp++;
        if (bcd10 !== 16'h1023) begin
            n_bad++;
            $display("FAIL sweep10_fullscale: bcd=%h, required 1023", bcd10);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        start     = 1'b0;
        bindata   = '0;
        start10   = 1'b0;
        bindata10 = '0;
        test_reset();
        test_latency_255();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_sweep8();
        test_sweep10();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
